// File: rtl/if_branch_feedback_ctrl_pkg.sv
// Shared definitions for the IF branch feedback path: FSM encoding, the
// stash entry layout and the prediction encoding used by the 1-bit BHT.
package if_bp_pkg;

  // Sequencer states: normal operation, flush pulse, one-cycle bubble.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } bp_state_e;

  // BHT encoding of a prediction; shared with the table itself.
  localparam logic PREDICTION_TAKE  = 1'b1;
  localparam logic PREDICTION_NTAKE = 1'b0;

  // One in-flight branch as captured at fetch.
  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] target;
  } stash_entry_t;

  localparam int ENTRY_W = $bits(stash_entry_t);  // 65

  // Sequential fall-through fetch address after a branch (wraps at 2^32).
  function automatic logic [31:0] fallthrough_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_branch_feedback_ctrl_if.sv
// Bundle of the IF push, EX resolve, BHT feedback and flush signals.
// The controller sits on the slave side; the pipeline/bench on the master side.
interface if_branch_feedback_ctrl_if #(
  parameter int PTR_W = 2,
  parameter int CNT_W = 16
) ();

  // IF side
  logic              if_push;
  logic [31:0]       if_push_pc;
  logic              if_push_pred;
  logic [31:0]       if_push_target;
  logic              if_ready;
  // EX side
  logic              ex_resolve;
  logic              ex_taken;
  logic [31:0]       ex_target;
  // BHT update port
  logic              pc_jmp_feedback;
  logic              pc_jmp_take;
  logic [31:0]       pc_stash_base;
  // Pipeline redirect
  logic              flush;
  logic [31:0]       flush_pc;
  // Status
  logic [PTR_W:0]    inflight_count;
  logic [CNT_W-1:0]  mispredict_cnt;
  logic              err_underflow;

  modport master (
    output if_push, if_push_pc, if_push_pred, if_push_target,
    output ex_resolve, ex_taken, ex_target,
    input  if_ready, pc_jmp_feedback, pc_jmp_take, pc_stash_base,
    input  flush, flush_pc, inflight_count, mispredict_cnt, err_underflow
  );

  modport slave (
    input  if_push, if_push_pc, if_push_pred, if_push_target,
    input  ex_resolve, ex_taken, ex_target,
    output if_ready, pc_jmp_feedback, pc_jmp_take, pc_stash_base,
    output flush, flush_pc, inflight_count, mispredict_cnt, err_underflow
  );

endinterface

// File: rtl/if_bp_stash_fifo.sv
// In-order stash of predicted branches awaiting EX resolution.
// Push at tail, pop at head, synchronous clear (wins over push/pop).
module if_bp_stash_fifo
  import if_bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_push,
  input  stash_entry_t   i_push_entry,
  input  logic           i_pop,
  input  logic           i_clear,
  output stash_entry_t   o_head,
  output logic [PTR_W:0] o_count,
  output logic           o_full,
  output logic           o_empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic               w_do_push;
  logic               w_do_pop;

  // Qualify requests against occupancy so the stash can never over/underflow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_do_push = i_push && !o_full && !i_clear;
    w_do_pop  = i_pop && !o_empty && !i_clear;
  end

  // Entry storage.
  // NOTE: the data array has no reset; occupancy is tracked by the pointers/count, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

  // Pointers and occupancy; pointers wrap naturally modulo DEPTH (power of 2).
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = stash_entry_t'(r_mem[r_rd_ptr]);
  assign o_count = r_count;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/if_branch_feedback_ctrl.sv
// Pairs predicted branches from IF with their EX resolution, trains the BHT,
// detects mispredicts and sequences a one-cycle flush plus one bubble cycle.
module if_branch_feedback_ctrl
  import if_bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  if_branch_feedback_ctrl_if.slave bus
);

  bp_state_e        r_state, w_state_nxt;
  stash_entry_t     w_head;
  stash_entry_t     w_push_entry;
  logic [PTR_W:0]   w_count;
  logic             w_full, w_empty;
  logic             w_run, w_ready, w_push_en, w_pop_en;
  logic             w_underflow_ev, w_actual, w_mispredict;
  logic [31:0]      w_redirect_pc;

  logic             r_fb;
  logic             r_take;
  logic [31:0]      r_base;
  logic             r_flush;
  logic [31:0]      r_flush_pc;
  logic [CNT_W-1:0] r_mis_cnt;
  logic             r_err;

  assign w_push_entry = '{pc: bus.if_push_pc, pred: bus.if_push_pred, target: bus.if_push_target};

  if_bp_stash_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_stash (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push_en),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop_en),
    .i_clear      (w_mispredict),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  // Handshake qualification, mispredict compare and next-state selection.
  always_comb begin
    w_state_nxt    = r_state;
    w_run          = (r_state == ST_RUN);
    w_ready        = w_run && !w_full;
    w_push_en      = bus.if_push && w_ready;
    w_pop_en       = w_run && bus.ex_resolve && !w_empty;
    w_underflow_ev = w_run && bus.ex_resolve && w_empty;
    w_actual       = bus.ex_taken ? PREDICTION_TAKE : PREDICTION_NTAKE;
    w_mispredict   = w_pop_en &&
                     ((w_head.pred != w_actual) ||
                      ((w_head.pred == PREDICTION_TAKE) && bus.ex_taken &&
                       (w_head.target != bus.ex_target)));
    w_redirect_pc  = bus.ex_taken ? bus.ex_target : fallthrough_pc(w_head.pc);
    case (r_state)
      ST_RUN:     if (w_mispredict) w_state_nxt = ST_FLUSH;
      ST_FLUSH:   w_state_nxt = ST_RECOVER;
      ST_RECOVER: w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // Registered BHT feedback, flush redirect and status counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fb       <= 1'b0;
      r_take     <= 1'b0;
      r_base     <= '0;
      r_flush    <= 1'b0;
      r_flush_pc <= '0;
      r_mis_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_fb    <= w_pop_en;
      r_flush <= w_mispredict;
      if (w_pop_en) begin
        r_take <= bus.ex_taken;
        r_base <= w_head.pc;
      end
      if (w_mispredict) begin
        r_flush_pc <= w_redirect_pc;
        if (r_mis_cnt != '1) r_mis_cnt <= r_mis_cnt + CNT_W'(1);
      end
      if (w_underflow_ev) r_err <= 1'b1;
    end
  end

  assign bus.if_ready        = w_ready;
  assign bus.pc_jmp_feedback = r_fb;
  assign bus.pc_jmp_take     = r_take;
  assign bus.pc_stash_base   = r_base;
  assign bus.flush           = r_flush;
  assign bus.flush_pc        = r_flush_pc;
  assign bus.inflight_count  = w_count;
  assign bus.mispredict_cnt  = r_mis_cnt;
  assign bus.err_underflow   = r_err;

endmodule

// File: tb/tb_if_branch_feedback_ctrl.sv
// Directed bench for if_branch_feedback_ctrl: hand-computed expectations
// for feedback, mispredict flush, full/empty handling and reset.
module tb_if_branch_feedback_ctrl;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  if_branch_feedback_ctrl_if #(.PTR_W(2), .CNT_W(16)) bp_if ();

  if_branch_feedback_ctrl #(.DEPTH(4), .PTR_W(2), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bp_if.if_push        = 1'b0;
    bp_if.if_push_pc     = '0;
    bp_if.if_push_pred   = 1'b0;
    bp_if.if_push_target = '0;
    bp_if.ex_resolve     = 1'b0;
    bp_if.ex_taken       = 1'b0;
    bp_if.ex_target      = '0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
    bp_if.if_push        = 1'b1;
    bp_if.if_push_pc     = pc;
    bp_if.if_push_pred   = pred;
    bp_if.if_push_target = tgt;
  endtask

  task automatic set_resolve(input logic taken, input logic [31:0] tgt);
    bp_if.ex_resolve = 1'b1;
    bp_if.ex_taken   = taken;
    bp_if.ex_target  = tgt;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
    set_push(pc, pred, tgt);
    tick();
    idle();
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    idle();
    reset = 1'b1;
    #12;
    check("rst_feedback", {31'd0, bp_if.pc_jmp_feedback}, 32'd0);
    check("rst_flush",    {31'd0, bp_if.flush}, 32'd0);
    check("rst_count",    32'(bp_if.inflight_count), 32'd0);
    check("rst_miscnt",   32'(bp_if.mispredict_cnt), 32'd0);
    check("rst_ready",    {31'd0, bp_if.if_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // 1: correct taken prediction
    push_one(32'h100, 1'b1, 32'h200);
    check("t1_count", 32'(bp_if.inflight_count), 32'd1);
    set_resolve(1'b1, 32'h200);
    tick();
    idle();
    check("t1_fb",    {31'd0, bp_if.pc_jmp_feedback}, 32'd1);
    check("t1_take",  {31'd0, bp_if.pc_jmp_take}, 32'd1);
    check("t1_base",  bp_if.pc_stash_base, 32'h100);
    check("t1_flush", {31'd0, bp_if.flush}, 32'd0);
    tick();
    check("t1_fb_pulse", {31'd0, bp_if.pc_jmp_feedback}, 32'd0);

    // 2: predicted taken, actually not taken
    push_one(32'h40, 1'b1, 32'h80);
    set_resolve(1'b0, 32'h0);
    tick();
    idle();
    check("t2_flush",    {31'd0, bp_if.flush}, 32'd1);
    check("t2_flush_pc", bp_if.flush_pc, 32'h44);
    check("t2_take",     {31'd0, bp_if.pc_jmp_take}, 32'd0);
    check("t2_fb",       {31'd0, bp_if.pc_jmp_feedback}, 32'd1);
    check("t2_count",    32'(bp_if.inflight_count), 32'd0);
    check("t2_miscnt",   32'(bp_if.mispredict_cnt), 32'd1);
    check("t2_ready_c1", {31'd0, bp_if.if_ready}, 32'd0);
    set_push(32'h999, 1'b0, 32'h0);   // must be ignored in FLUSH
    tick();
    idle();
    check("t2_flush_pulse", {31'd0, bp_if.flush}, 32'd0);
    check("t2_ready_c2",    {31'd0, bp_if.if_ready}, 32'd0);
    check("t2_push_ignored", 32'(bp_if.inflight_count), 32'd0);
    tick();
    check("t2_ready_back", {31'd0, bp_if.if_ready}, 32'd1);
    check("t2_flush_pc_hold", bp_if.flush_pc, 32'h44);

    // 3: fill, push+resolve at full, drain in order
    for (int i = 0; i < 4; i++) push_one(32'h1000 + 32'(i) * 32'h10, 1'b0, 32'h0);
    check("t3_full_count", 32'(bp_if.inflight_count), 32'd4);
    check("t3_full_ready", {31'd0, bp_if.if_ready}, 32'd0);
    set_push(32'h2000, 1'b0, 32'h0);
    set_resolve(1'b0, 32'h0);
    tick();
    idle();
    check("t3_count_after", 32'(bp_if.inflight_count), 32'd3);
    check("t3_base0",       bp_if.pc_stash_base, 32'h1000);
    check("t3_no_flush",    {31'd0, bp_if.flush}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      set_resolve(1'b0, 32'h0);
      tick();
      idle();
      check($sformatf("t3_base%0d", i), bp_if.pc_stash_base, 32'h1000 + 32'(i) * 32'h10);
    end
    check("t3_drained", 32'(bp_if.inflight_count), 32'd0);
    // push+resolve when not full: both act
    push_one(32'h3000, 1'b0, 32'h0);
    set_push(32'h3010, 1'b0, 32'h0);
    set_resolve(1'b0, 32'h0);
    tick();
    idle();
    check("t3_pr_count", 32'(bp_if.inflight_count), 32'd1);
    check("t3_pr_base",  bp_if.pc_stash_base, 32'h3000);
    set_resolve(1'b0, 32'h0);
    tick();
    idle();
    check("t3_pr_base2", bp_if.pc_stash_base, 32'h3010);

    // 4: taken as predicted but wrong target
    push_one(32'h500, 1'b1, 32'h300);
    set_resolve(1'b1, 32'h380);
    tick();
    idle();
    check("t4_flush",    {31'd0, bp_if.flush}, 32'd1);
    check("t4_flush_pc", bp_if.flush_pc, 32'h380);
    check("t4_take",     {31'd0, bp_if.pc_jmp_take}, 32'd1);
    check("t4_base",     bp_if.pc_stash_base, 32'h500);
    check("t4_miscnt",   32'(bp_if.mispredict_cnt), 32'd2);
    tick();
    tick();
    check("t4_ready", {31'd0, bp_if.if_ready}, 32'd1);

    // 5: resolve on empty stash
    set_resolve(1'b1, 32'h123);
    tick();
    idle();
    check("t5_fb",     {31'd0, bp_if.pc_jmp_feedback}, 32'd0);
    check("t5_flush",  {31'd0, bp_if.flush}, 32'd0);
    check("t5_err",    {31'd0, bp_if.err_underflow}, 32'd1);
    check("t5_miscnt", 32'(bp_if.mispredict_cnt), 32'd2);
    tick();
    tick();
    check("t5_err_sticky", {31'd0, bp_if.err_underflow}, 32'd1);

    // 6a: async reset with three entries in flight
    for (int i = 0; i < 3; i++) push_one(32'h700 + 32'(i) * 32'h4, 1'b0, 32'h0);
    check("t6_count3", 32'(bp_if.inflight_count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("t6a_count",  32'(bp_if.inflight_count), 32'd0);
    check("t6a_err",    {31'd0, bp_if.err_underflow}, 32'd0);
    check("t6a_miscnt", 32'(bp_if.mispredict_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // 6b: async reset while the FSM is in FLUSH
    push_one(32'h800, 1'b0, 32'h0);
    set_resolve(1'b1, 32'h900);
    tick();
    idle();
    check("t6b_in_flush", {31'd0, bp_if.flush}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("t6b_flush",    {31'd0, bp_if.flush}, 32'd0);
    check("t6b_flush_pc", bp_if.flush_pc, 32'h0);
    check("t6b_fb",       {31'd0, bp_if.pc_jmp_feedback}, 32'd0);
    check("t6b_base",     bp_if.pc_stash_base, 32'h0);
    check("t6b_count",    32'(bp_if.inflight_count), 32'd0);
    check("t6b_miscnt",   32'(bp_if.mispredict_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("t6b_run_ready", {31'd0, bp_if.if_ready}, 32'd1);
    push_one(32'hA00, 1'b0, 32'h0);
    check("t6b_push_ok", 32'(bp_if.inflight_count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
